// File: rtl/trap_sequencer.sv
// Trap/MRET/double-fault sequencer: redirect comes FLUSH_CYCLES+1 cycles after an exception, and inputs are ignored outside BOOT/RUN/HANDLER.
// There is no backpressure. Defining TRAP_SEQUENCER_COUNT_EN enables the saturating o_trap_count; otherwise it is tied to 0.
module trap_sequencer #(
  parameter logic [31:0] TRAP_VECTOR  = 32'h0000_0000,
  parameter logic [31:0] RESET_VECTOR = 32'h0004_0000,
  parameter logic [31:0] TEXT_BASE    = 32'h0008_0000,
  parameter int unsigned FLUSH_CYCLES = 2
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic [3:0]  i_exception_code_f,
  input  logic [3:0]  i_exception_code_e,
  input  logic [31:0] i_pc_f,
  input  logic [31:0] i_pc_e,
  input  logic        i_mret_e,
  output logic        o_flush,
  output logic        o_stall_f,
  output logic        o_redirect_valid,
  output logic [31:0] o_redirect_pc,
  output logic [31:0] o_mepc,
  output logic [3:0]  o_mcause,
  output logic        o_trap_permission,
  output logic        o_reset_permission,
  output logic [15:0] o_trap_count
);

  localparam logic [2:0] S_BOOT    = 3'd0;
  localparam logic [2:0] S_RUN     = 3'd1;
  localparam logic [2:0] S_FLUSH   = 3'd2;
  localparam logic [2:0] S_VECTOR  = 3'd3;
  localparam logic [2:0] S_HANDLER = 3'd4;
  localparam logic [2:0] S_RET     = 3'd5;

  localparam logic [2:0] FLUSH_LOAD = 3'(FLUSH_CYCLES);

  logic [2:0]  state;
  logic [2:0]  state_nxt;
  logic [2:0]  flush_cnt;
  logic [31:0] ret_target;
  logic        exc_e_vld;
  logic        exc_any;
  logic [3:0]  exc_code;
  logic [31:0] exc_pc;

  // Execute-stage exception is the older instruction, so it wins over fetch.
  assign exc_e_vld = |i_exception_code_e;
  assign exc_any   = exc_e_vld || (|i_exception_code_f);
  assign exc_code  = exc_e_vld ? i_exception_code_e : i_exception_code_f;
  assign exc_pc    = exc_e_vld ? i_pc_e : i_pc_f;

  always_comb begin
    state_nxt = state;
    case (state)
      S_BOOT:    if (i_mret_e) state_nxt = S_RET;
      S_RUN:     if (exc_any) state_nxt = S_FLUSH;
      S_FLUSH:   if (flush_cnt <= 3'd1) state_nxt = S_VECTOR;
      S_VECTOR:  state_nxt = S_HANDLER;
      S_HANDLER: begin
        if (exc_any)       state_nxt = S_BOOT;
        else if (i_mret_e) state_nxt = S_RET;
      end
      S_RET:     state_nxt = S_RUN;
      default:   state_nxt = S_BOOT;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state      <= S_BOOT;
      flush_cnt  <= 3'd0;
      o_mepc     <= 32'd0;
      o_mcause   <= 4'd0;
      ret_target <= 32'd0;
    end else begin
      state <= state_nxt;
      case (state)
        S_BOOT: if (i_mret_e) ret_target <= TEXT_BASE;
        S_RUN: begin
          if (exc_any) begin
            o_mepc    <= exc_pc;
            o_mcause  <= exc_code;
            flush_cnt <= FLUSH_LOAD;
          end
        end
        S_FLUSH: flush_cnt <= flush_cnt - 3'd1;
        S_HANDLER: begin
          // Double fault records the new cause but keeps the original mepc.
          if (exc_any)       o_mcause   <= exc_code;
          else if (i_mret_e) ret_target <= o_mepc;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    o_flush            = 1'b0;
    o_stall_f          = 1'b0;
    o_redirect_valid   = 1'b0;
    o_redirect_pc      = 32'd0;
    o_trap_permission  = 1'b0;
    o_reset_permission = 1'b0;
    case (state)
      S_BOOT:  o_reset_permission = 1'b1;
      S_FLUSH: begin
        o_flush   = 1'b1;
        o_stall_f = 1'b1;
      end
      S_VECTOR: begin
        o_flush          = 1'b1;
        o_redirect_valid = 1'b1;
        o_redirect_pc    = TRAP_VECTOR;
      end
      S_HANDLER: begin
        o_trap_permission = 1'b1;
        if (exc_any) begin
          o_flush          = 1'b1;
          o_redirect_valid = 1'b1;
          o_redirect_pc    = RESET_VECTOR;
        end
      end
      S_RET: begin
        o_flush          = 1'b1;
        o_redirect_valid = 1'b1;
        o_redirect_pc    = ret_target;
      end
      default: ;
    endcase
  end

`ifdef TRAP_SEQUENCER_COUNT_EN
  logic [15:0] trap_cnt;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      trap_cnt <= 16'd0;
    end else if ((state == S_RUN) && exc_any && (trap_cnt != 16'hFFFF)) begin
      trap_cnt <= trap_cnt + 16'd1;
    end
  end

  assign o_trap_count = trap_cnt;
`else
  assign o_trap_count = 16'd0;
`endif

endmodule
